fmw_row_scheduler: RTL and testbench

Sequencing controller for the FM×WM product row memory in the GCN accelerator. It drives the memory's write port from the combination stage (feature×weight rows) and arbitrates the aggregation stage's adjacency-driven row reads. It tracks which rows of the current pass hold valid data, so reads of rows not yet written stall instead of returning stale data. One pass is FEATURE_ROWS writes followed by reads until the consumer signals its last access.

---
 rtl/fmw_row_scheduler.sv | 140 ++++++++++++++
 tb/tb_fmw_row_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fmw_row_scheduler.sv
// Write/read sequencing controller for the FM x WM product row memory.
// Optional stall-cycle counter port enabled by defining FMW_SCHED_PERF_EN.
module fmw_row_scheduler #(
    parameter int FEATURE_ROWS  = 6,
    parameter int FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    output logic                     wr_en,
    output logic [FEATURE_WIDTH-1:0] write_row,
    input  logic                     rd_req,
    input  logic [FEATURE_WIDTH-1:0] rd_row_req,
    input  logic                     rd_last,
    output logic                     rd_grant,
    output logic [FEATURE_WIDTH-1:0] read_row,
    output logic [FEATURE_WIDTH:0]   rows_written,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_err
`ifdef FMW_SCHED_PERF_EN
    ,
    output logic [15:0]              stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [FEATURE_WIDTH:0]   ROWS_EXT = (FEATURE_WIDTH+1)'(FEATURE_ROWS);
    localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);

    state_t                   state;
    state_t                   state_next;
    logic [FEATURE_WIDTH-1:0] wr_ptr;
    logic [FEATURE_ROWS-1:0]  valid;
    logic                     arb_active;
    logic                     row_in_range;
    logic                     row_valid;
    logic                     pass_start;

    assign pass_start   = (state == IDLE) && start;
    assign row_in_range = ({1'b0, rd_row_req} < ROWS_EXT);
    assign read_row     = rd_row_req;
    assign write_row    = wr_ptr;

    // Decoded lookup keeps out-of-range indices from touching the valid vector.
    always_comb begin
        row_valid = 1'b0;
        for (int i = 0; i < FEATURE_ROWS; i++) begin
            if (rd_row_req == FEATURE_WIDTH'(i)) row_valid = valid[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (wr_en && (wr_ptr == LAST_ROW)) state_next = SERVE;
            SERVE:   if (rd_req && rd_grant && rd_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant only reads of rows written at an earlier edge; no write-to-read bypass.
    always_comb begin
        prod_ready = 1'b0;
        wr_en      = 1'b0;
        arb_active = 1'b0;
        rd_grant   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            FILL: begin
                prod_ready = 1'b1;
                wr_en      = prod_valid;
                arb_active = 1'b1;
                busy       = 1'b1;
            end
            SERVE: begin
                arb_active = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
        rd_grant = arb_active && rd_req && row_in_range && row_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            valid        <= '0;
            rows_written <= '0;
            rd_err       <= 1'b0;
        end else if (pass_start) begin
            wr_ptr       <= '0;
            valid        <= '0;
            rows_written <= '0;
            rd_err       <= 1'b0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < FEATURE_ROWS; i++) begin
                    if (wr_ptr == FEATURE_WIDTH'(i)) valid[i] <= 1'b1;
                end
                rows_written <= rows_written + 1'b1;
                if (wr_ptr != LAST_ROW) wr_ptr <= wr_ptr + 1'b1;
            end
            if (arb_active && rd_req && !row_in_range) rd_err <= 1'b1;
        end
    end

`ifdef FMW_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (pass_start) begin
            stall_cycles <= '0;
        end else if (arb_active && rd_req && !rd_grant && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fmw_row_scheduler.sv
// Table-driven bench for fmw_row_scheduler with a queue-based expected-value scoreboard.
// Covers fill/serve pass, early reads, write/read hazard, out-of-range reads, gaps, mid-pass reset.
module tb_fmw_row_scheduler;

    localparam int ROWS = 6;
    localparam int W    = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           prod_valid;
    logic           prod_ready;
    logic           wr_en;
    logic [W-1:0]   write_row;
    logic           rd_req;
    logic [W-1:0]   rd_row_req;
    logic           rd_last;
    logic           rd_grant;
    logic [W-1:0]   read_row;
    logic [W:0]     rows_written;
    logic           busy;
    logic           done;
    logic           rd_err;
`ifdef FMW_SCHED_PERF_EN
    logic [15:0]    stall_cycles;
`endif

    fmw_row_scheduler #(.FEATURE_ROWS(ROWS), .FEATURE_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .wr_en(wr_en), .write_row(write_row),
        .rd_req(rd_req), .rd_row_req(rd_row_req), .rd_last(rd_last),
        .rd_grant(rd_grant), .read_row(read_row), .rows_written(rows_written),
        .busy(busy), .done(done), .rd_err(rd_err)
`ifdef FMW_SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic st, pv, rq;
        int   row;
        logic last;
        logic e_ready, e_wr;
        int   e_wrow;
        logic e_grant;
        int   e_rw;
        logic e_busy, e_done, e_err;
        int   e_stall;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic st, pv, rq, input int row, input logic last,
                       input logic e_ready, e_wr, input int e_wrow, input logic e_grant,
                       input int e_rw, input logic e_busy, e_done, e_err, input int e_stall);
        vec_t v;
        v.st = st; v.pv = pv; v.rq = rq; v.row = row; v.last = last;
        v.e_ready = e_ready; v.e_wr = e_wr; v.e_wrow = e_wrow; v.e_grant = e_grant;
        v.e_rw = e_rw; v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
        v.e_stall = e_stall;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic compare_now(input int idx);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard vec %0d: got empty queue expected entry", idx);
            return;
        end
        e = exp_q.pop_front();
        n_vec++;
        chk("prod_ready",   idx, int'(prod_ready),   int'(e.e_ready));
        chk("wr_en",        idx, int'(wr_en),        int'(e.e_wr));
        chk("write_row",    idx, int'(write_row),    e.e_wrow);
        chk("rd_grant",     idx, int'(rd_grant),     int'(e.e_grant));
        chk("read_row",     idx, int'(read_row),     e.row);
        chk("rows_written", idx, int'(rows_written), e.e_rw);
        chk("busy",         idx, int'(busy),         int'(e.e_busy));
        chk("done",         idx, int'(done),         int'(e.e_done));
        chk("rd_err",       idx, int'(rd_err),       int'(e.e_err));
`ifdef FMW_SCHED_PERF_EN
        chk("stall_cycles", idx, int'(stall_cycles), e.e_stall);
`endif
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            start      = vecs[i].st;
            prod_valid = vecs[i].pv;
            rd_req     = vecs[i].rq;
            rd_row_req = W'(vecs[i].row);
            rd_last    = vecs[i].last;
            exp_q.push_back(vecs[i]);
            #2;
            compare_now(i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //  st pv rq row last | rdy wr wrow gnt rw busy done err stall
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);   // 0 start
        add(0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0, 0, 0);   // 1 write row 0
        add(0, 1, 1, 3, 0,   1, 1, 1, 0, 1, 1, 0, 0, 0);   // 2 early read of row 3
        add(0, 1, 1, 3, 0,   1, 1, 2, 0, 2, 1, 0, 0, 1);
        add(0, 1, 1, 3, 0,   1, 1, 3, 0, 3, 1, 0, 0, 2);   // 4 write row 3 while reading it
        add(0, 0, 1, 3, 0,   1, 0, 4, 1, 4, 1, 0, 0, 3);   // 5 granted after write edge
        add(0, 1, 1, 4, 0,   1, 1, 4, 0, 4, 1, 0, 0, 3);   // 6 same-row hazard
        add(0, 1, 1, 0, 1,   1, 1, 5, 1, 5, 1, 0, 0, 4);   // 7 last row + other-row read, rd_last in FILL
        add(0, 1, 1, 4, 0,   0, 0, 5, 1, 6, 1, 0, 0, 4);   // 8 SERVE, prod_valid ignored
        add(0, 0, 1, 7, 0,   0, 0, 5, 0, 6, 1, 0, 0, 4);   // 9 out of range
        add(0, 0, 1, 5, 0,   0, 0, 5, 1, 6, 1, 0, 1, 5);
        add(0, 0, 1, 7, 1,   0, 0, 5, 0, 6, 1, 0, 1, 5);   // 11 rd_last without grant
        add(0, 0, 1, 2, 1,   0, 0, 5, 1, 6, 1, 0, 1, 6);   // 12 final read
        add(1, 1, 1, 1, 0,   0, 0, 5, 0, 6, 1, 1, 1, 6);   // 13 DONE, start ignored
        add(0, 1, 1, 0, 0,   0, 0, 5, 0, 6, 0, 0, 1, 6);   // 14 IDLE, no write, no grant
        add(1, 0, 0, 0, 0,   0, 0, 5, 0, 6, 0, 0, 1, 6);   // 15 new pass
        add(0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0, 0);   // 16 valid cleared, err cleared
        add(0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0, 0, 1);   // 17 gaps in producer
        add(0, 0, 0, 0, 0,   1, 0, 1, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0,   1, 1, 1, 1, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0,   1, 0, 2, 0, 2, 1, 0, 0, 1);
        add(0, 1, 0, 0, 0,   1, 1, 2, 0, 2, 1, 0, 0, 1);   // 21 third row written
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);   // 22 after mid-FILL reset: start
        add(0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0, 0);   // 23 row 0 denied
        add(0, 1, 1, 0, 0,   1, 1, 0, 0, 0, 1, 0, 0, 1);   // 24 rewrite row 0 while reading
        add(0, 0, 1, 0, 0,   1, 0, 1, 1, 1, 1, 0, 0, 2);   // 25 now granted

        reset = 1'b1; start = 1'b0; prod_valid = 1'b0; rd_req = 1'b0;
        rd_row_req = '0; rd_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        n_vec++;
        chk("reset_busy",      -1, int'(busy),         0);
        chk("reset_ready",     -1, int'(prod_ready),   0);
        chk("reset_rows",      -1, int'(rows_written), 0);
        chk("reset_write_row", -1, int'(write_row),    0);
        chk("reset_done",      -1, int'(done),         0);
        chk("reset_err",       -1, int'(rd_err),       0);

        run(0, 21);

        // Asynchronous reset mid-FILL: outputs must drop before any clock edge.
        @(negedge clk);
        prod_valid = 1'b1; rd_req = 1'b1; rd_row_req = 3'd5; start = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_vec++;
        chk("midreset_ready",     -2, int'(prod_ready),   0);
        chk("midreset_wr_en",     -2, int'(wr_en),        0);
        chk("midreset_write_row", -2, int'(write_row),    0);
        chk("midreset_grant",     -2, int'(rd_grant),     0);
        chk("midreset_read_row",  -2, int'(read_row),     5);
        chk("midreset_rows",      -2, int'(rows_written), 0);
        chk("midreset_busy",      -2, int'(busy),         0);
        chk("midreset_done",      -2, int'(done),         0);
        chk("midreset_err",       -2, int'(rd_err),       0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        prod_valid = 1'b0; rd_req = 1'b0;

        run(22, 25);

        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
